// File: rtl/parity_frame_checker.sv
// Frame parity checker: accumulates ones-count and parity over FRAME_LEN words
// delimited by sof, then issues a registered pass/fail verdict and a failed-frame count.
module parity_frame_checker #(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 4,
    parameter int ODD       = 0,
    parameter int ERR_W     = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 enb,
    input  logic                                 sof,
    input  logic [WIDTH-1:0]                     c,
    output logic                                 n,
    output logic                                 done,
    output logic [$clog2(WIDTH*FRAME_LEN+1)-1:0] ones,
    output logic                                 par_run,
    output logic                                 busy,
    output logic [ERR_W-1:0]                     err_cnt
);

    localparam int OW = $clog2(WIDTH*FRAME_LEN+1);
    localparam int IW = $clog2(FRAME_LEN+1);
    localparam int PW = $clog2(WIDTH+1);
    localparam logic ODD_B = (ODD != 0);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] ACC  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [OW-1:0]    acc_q, acc_d;
    logic             par_q, par_d;
    logic             n_q, n_d;
    logic             done_q, done_d;
    logic [OW-1:0]    ones_q, ones_d;
    logic [ERR_W-1:0] err_q, err_d;

    logic [PW-1:0]    pc;
    logic             take;
    logic [OW-1:0]    sum_acc;
    logic             sum_par;
    logic [IW-1:0]    sum_idx;

    always_comb begin
        pc = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            pc = pc + PW'(c[i]);
        end
    end

    // sof restarts from an empty frame whether idle or mid-frame (abort).
    always_comb begin
        take    = enb && (sof || (state_q == ACC));
        sum_acc = (sof ? '0 : acc_q) + OW'(pc);
        sum_par = (sof ? 1'b0 : par_q) ^ (^c);
        sum_idx = (sof ? '0 : idx_q) + IW'(1);
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        par_d   = par_q;
        n_d     = n_q;
        done_d  = 1'b0;
        ones_d  = ones_q;
        err_d   = err_q;
        if (take) begin
            if (sum_idx == IW'(FRAME_LEN)) begin
                state_d = IDLE;
                idx_d   = '0;
                acc_d   = '0;
                par_d   = 1'b0;
                ones_d  = sum_acc;
                n_d     = (sum_par == ODD_B);
                done_d  = 1'b1;
                if ((sum_par != ODD_B) && (err_q != '1)) begin
                    err_d = err_q + ERR_W'(1);
                end
            end else begin
                state_d = ACC;
                idx_d   = sum_idx;
                acc_d   = sum_acc;
                par_d   = sum_par;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            par_q   <= 1'b0;
            n_q     <= 1'b1;
            done_q  <= 1'b0;
            ones_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            par_q   <= par_d;
            n_q     <= n_d;
            done_q  <= done_d;
            ones_q  <= ones_d;
            err_q   <= err_d;
        end
    end

    assign n       = n_q;
    assign done    = done_q;
    assign ones    = ones_q;
    assign par_run = par_q;
    assign busy    = (state_q == ACC);
    assign err_cnt = err_q;

    // The verdict must agree with the parity of the reported ones count.
    a_verdict_matches_ones : assert property (
        @(posedge clk) disable iff (!rst) done |-> (n == (ones[0] == ODD_B))
    );

endmodule

// File: doc/parity_frame_checker.md
Name: parity_frame_checker

Overview:
Parametrised successor to the single-word parity vend block. Accumulates parity and ones-count over a frame of FRAME_LEN words of WIDTH bits. Each frame is delimited by sof. At the end of each frame the block issues a registered pass/fail verdict, and it keeps a saturating count of failed frames. It sits between the coin/data capture front end and the vend controller, which consumes done/n.

Parameters:
WIDTH, 8, data word width in bits (>=1)
FRAME_LEN, 4, words per frame (>=1)
ODD, 0, required frame parity: 0 = even number of ones passes, 1 = odd passes
ERR_W, 8, width of the failed-frame counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-low reset (rst==0 at a rising clk edge resets the block)
enb  in  1  word-valid qualifier, sampled synchronously; not used as a clock
sof  in  1  start-of-frame, meaningful only when enb==1
c    in  WIDTH  data word
n    out  1  verdict of the last completed frame: 1 = pass, 0 = fail; held between frames
done  out  1  one-cycle pulse, frame verdict updated this cycle
ones  out  $clog2(WIDTH*FRAME_LEN+1)  ones count of the last completed frame; held
par_run  out  1  running XOR parity of the words accepted so far in the current frame
busy  out  1  frame in progress (state ACC)
err_cnt  out  ERR_W  count of failed frames, saturates at all-ones

Behaviour:
- Reset values (rst==0 at clk edge): state=IDLE, n=1, done=0, ones=0, par_run=0, busy=0, err_cnt=0, word index=0, accumulators=0. Reset takes priority over every other input, including in the middle of a frame; a partial frame is discarded with no done pulse.
- A word is accepted at a clk edge with enb==1 and is processed under the state rules below. Per-word ones = popcount(c), computed combinationally and summed at full width with no truncation.
- States: IDLE and ACC.
- IDLE, enb&sof:
  - Start a frame: acc_ones=popcount(c), par_run=^c, idx=1.
  - If FRAME_LEN==1, complete the frame immediately (see completion) and stay in IDLE; otherwise go to ACC.
- IDLE, enb&!sof: word ignored; no state change.
- ACC, enb&!sof: acc_ones+=popcount(c), par_run^=^c, idx+=1. When this is word FRAME_LEN (idx reaches FRAME_LEN), complete the frame and go to IDLE.
- ACC, enb&sof: abort the current frame (no done pulse, err_cnt unchanged) and restart with this word exactly as in IDLE&sof. sof always wins over continuation.
- ACC, !enb: hold all state. There is no timeout; gaps of any length are allowed.
- Completion, effective at the same clk edge as the last accepted word:
  - Registered outputs update on that edge, so latency is one cycle from last word to done.
  - ones = final acc_ones.
  - n = (final parity == ODD).
  - done = 1 for exactly one cycle.
  - If n==0, err_cnt increments, saturating at 2^ERR_W-1.
  - par_run clears to 0 on the cycle after completion.
- done is deasserted on every cycle that does not complete a frame.
- Back-to-back frames with no idle cycles are supported: a sof word on the cycle after completion starts the next frame, and done pulses never merge.
- The final parity used for n equals ones[0]; the two must agree at every done (assertion).
- busy==1 exactly in ACC. For FRAME_LEN==1, busy stays 0.

Test Plan:
- Reset, then WIDTH=8, FRAME_LEN=4, ODD=0; frame 0x01,0x03,0x00,0xFF with sof on the first word -> done pulses one cycle after 0xFF, ones=11, n=0, err_cnt=1.
- Frame 0x0F,0xF0,0x11,0x00 with enb gaps of 3 cycles between words -> ones=10, n=1, err_cnt unchanged, busy high from the first word until done.
- Mid-frame abort: two words, then sof with 0x07 followed by 0x00,0x00,0x00 -> a single done only, ones=3, n=0; the aborted frame is not counted.
- rst=0 after two words of a frame -> no done; all outputs return to reset values on the next edge; words with enb=1 and sof=0 are then ignored in IDLE.
- ERR_W=2: five consecutive failing frames sent back-to-back with no idle cycle -> five distinct done pulses; err_cnt goes 1,2,3,3,3.
- FRAME_LEN=1, ODD=1: sof word 0x80 -> done next cycle, n=1, ones=1, busy never asserted.
